result_psr_stage: RTL and testbench
===================================

RESULT_PSR_STAGE -- requirements
Module: result_psr_stage

Interface
REQ-001 SHALL have parameter word_Size, default 32, datapath width of result and output data.
REQ-002 SHALL have parameter Dest_Width, default 5, width of destination-register tag.
REQ-003 SHALL be clocked by one clock and reset asynchronously, active-low.
REQ-004 Clk  input  1  rising-edge clock for all state.
REQ-005 Reset_n  input  1  asynchronous active-low reset.
REQ-006 In_Valid  input  1  upstream ALU result and flags present this cycle.
REQ-007 In_Ready  output  1  stage can accept an entry this cycle.
REQ-008 ALU_Result  input  word_Size  result from arithmetic/logic unit.
REQ-009 C  input  1  carry flag from arithmetic/logic unit.
REQ-010 V  input  1  overflow flag from arithmetic/logic unit.
REQ-011 PSR_Write  input  1  entry updates processor status register.
REQ-012 Dest  input  Dest_Width  destination register tag travelling with result.
REQ-013 Flush  input  1  synchronous discard of all buffered entries.
REQ-014 Out_Valid  output  1  head entry presented downstream.
REQ-015 Out_Ready  input  1  downstream consumes head entry this cycle.
REQ-016 Out_Result  output  word_Size  head entry result.
REQ-017 Out_Dest  output  Dest_Width  head entry tag.
REQ-018 Out_Flags  output  4  head entry {N,Z,C,V} computed from its own result.
REQ-019 PSR  output  4  architectural status register {N,Z,C,V}.
REQ-020 Op_Count  output  16  count of accepted entries, saturating.

Function
REQ-021 SHALL buffer entries in a 2-entry FIFO; occupancy states EMPTY(0), ONE(1), FULL(2).
REQ-022 SHALL accept (push) when In_Valid && In_Ready at a rising edge.
REQ-023 SHALL drive In_Ready = 1 in EMPTY and ONE and 0 in FULL, combinationally from occupancy only.
REQ-024 SHALL pop the head when Out_Valid && Out_Ready at a rising edge.
REQ-025 SHALL drive Out_Valid = 1 iff occupancy is nonzero; Out_Result/Out_Dest/Out_Flags reflect head, zero when EMPTY.
REQ-026 Transitions: EMPTY-push->ONE; ONE-push-only->FULL; ONE-pop-only->EMPTY; ONE-push+pop->ONE (new entry becomes head next cycle); FULL-pop->ONE; otherwise hold.
REQ-027 SHALL compute per entry at push: N = ALU_Result[word_Size-1], Z = (ALU_Result == 0), C and V passed through.
REQ-028 SHALL update PSR at the push edge with that entry's {N,Z,C,V} iff PSR_Write = 1; else PSR holds.
REQ-029 Flush = 1 SHALL set occupancy to EMPTY next cycle, overriding any push or pop that cycle; the coincident input is not accepted, does not update PSR, does not count.
REQ-030 Flush SHALL NOT alter PSR or Op_Count.
REQ-031 Op_Count SHALL increment by 1 per accepted push and saturate at 16'hFFFF.
REQ-032 FIFO read/write pointers SHALL be 1-bit and wrap 1->0.
REQ-033 Latency: entry pushed at edge k is visible on outputs after edge k when FIFO was EMPTY (one cycle).
REQ-034 Outputs SHALL hold stable while Out_Valid = 1 and Out_Ready = 0.

Reset
REQ-035 Reset_n = 0 SHALL immediately force occupancy EMPTY, pointers 0, PSR = 4'b0000, Op_Count = 0, Out_Valid = 0, In_Ready = 1, data outputs 0.
REQ-036 Reset asserted mid-operation SHALL discard all buffered entries; first push after release behaves as from EMPTY.

Verification
REQ-037 Push ALU_Result=32'h80000000, C=1, V=1, PSR_Write=1, Dest=3 -> next cycle Out_Valid=1, Out_Flags=4'b1011, PSR=4'b1011, Out_Dest=3.
REQ-038 Push ALU_Result=0, C=0, V=0, PSR_Write=0 after REQ-037 entry -> Out_Flags of that entry=4'b0100, PSR stays 4'b1011.
REQ-039 Out_Ready=0, three consecutive In_Valid pushes -> third not accepted, In_Ready=0 while FULL, Op_Count=2.
REQ-040 FULL, Out_Ready=1 two cycles -> entries exit in push order, then Out_Valid=0, In_Ready=1.
REQ-041 ONE with simultaneous push+pop -> occupancy stays ONE, new entry at head next cycle; Flush with In_Valid=1 -> EMPTY, PSR and Op_Count unchanged.
REQ-042 Reset_n pulsed low while FULL -> outputs at reset values without waiting for Clk; Op_Count forced to 16'hFFFF via 65535 pushes then one more -> stays 16'hFFFF.

Source files
------------

// File: rtl/result_psr_stage.sv
// Result/PSR write-back stage: a 2-entry skid FIFO for ALU results that tags each entry
// with its own {N,Z,C,V} and optionally commits those flags to the architectural PSR.
module result_psr_stage #(
   parameter int word_Size  = 32,
   parameter int Dest_Width = 5
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  In_Valid,
   output logic                  In_Ready,
   input  logic [word_Size-1:0]  ALU_Result,
   input  logic                  C,
   input  logic                  V,
   input  logic                  PSR_Write,
   input  logic [Dest_Width-1:0] Dest,
   input  logic                  Flush,
   output logic                  Out_Valid,
   input  logic                  Out_Ready,
   output logic [word_Size-1:0]  Out_Result,
   output logic [Dest_Width-1:0] Out_Dest,
   output logic [3:0]            Out_Flags,
   output logic [3:0]            PSR,
   output logic [15:0]           Op_Count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_t;

   occ_t                  occ_reg;
   logic                  wr_ptr_reg;
   logic                  rd_ptr_reg;
   logic [3:0]            psr_reg;
   logic [15:0]           op_count_reg;

   logic [word_Size-1:0]  result_mem [2];
   logic [Dest_Width-1:0] dest_mem   [2];
   logic [3:0]            flags_mem  [2];

   logic                  push;
   logic                  pop;
   logic [3:0]            new_flags;

   assign In_Ready  = (occ_reg != FULL);
   assign Out_Valid = (occ_reg != EMPTY);

   // Flush wins over both handshakes, so neither side sees a transfer that cycle.
   assign push = In_Valid && In_Ready && !Flush;
   assign pop  = Out_Valid && Out_Ready && !Flush;

   assign new_flags = {ALU_Result[word_Size-1], (ALU_Result == '0), C, V};

   always_ff @(posedge Clk) begin
      if (push) begin
         result_mem[wr_ptr_reg] <= ALU_Result;
         dest_mem[wr_ptr_reg]   <= Dest;
         flags_mem[wr_ptr_reg]  <= new_flags;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         occ_reg      <= EMPTY;
         wr_ptr_reg   <= 1'b0;
         rd_ptr_reg   <= 1'b0;
         psr_reg      <= 4'b0000;
         op_count_reg <= 16'd0;
      end else if (Flush) begin
         occ_reg    <= EMPTY;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
      end else begin
         case (occ_reg)
            EMPTY:   if (push) occ_reg <= ONE;
            ONE: begin
               if (push && !pop)      occ_reg <= FULL;
               else if (pop && !push) occ_reg <= EMPTY;
            end
            FULL:    if (pop) occ_reg <= ONE;
            default: occ_reg <= EMPTY;
         endcase

         if (push) wr_ptr_reg <= ~wr_ptr_reg;
         if (pop)  rd_ptr_reg <= ~rd_ptr_reg;

         if (push && PSR_Write) psr_reg <= new_flags;
         if (push && (op_count_reg != 16'hFFFF)) op_count_reg <= op_count_reg + 16'd1;
      end
   end

   // Storage is not reset, so the head is masked to zero whenever nothing is buffered.
   assign Out_Result = Out_Valid ? result_mem[rd_ptr_reg] : '0;
   assign Out_Dest   = Out_Valid ? dest_mem[rd_ptr_reg]   : '0;
   assign Out_Flags  = Out_Valid ? flags_mem[rd_ptr_reg]  : 4'b0000;
   assign PSR        = psr_reg;
   assign Op_Count   = op_count_reg;

endmodule

// File: tb/tb_result_psr_stage.sv
// Self-checking bench for result_psr_stage: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_result_psr_stage;
   localparam int W  = 32;
   localparam int DW = 5;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic          In_Valid = 1'b0;
   logic          In_Ready;
   logic [W-1:0]  ALU_Result = '0;
   logic          C = 1'b0;
   logic          V = 1'b0;
   logic          PSR_Write = 1'b0;
   logic [DW-1:0] Dest = '0;
   logic          Flush = 1'b0;
   logic          Out_Valid;
   logic          Out_Ready = 1'b0;
   logic [W-1:0]  Out_Result;
   logic [DW-1:0] Out_Dest;
   logic [3:0]    Out_Flags;
   logic [3:0]    PSR;
   logic [15:0]   Op_Count;

   result_psr_stage #(.word_Size(W), .Dest_Width(DW)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
      .ALU_Result(ALU_Result), .C(C), .V(V), .PSR_Write(PSR_Write), .Dest(Dest),
      .Flush(Flush), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
      .Out_Result(Out_Result), .Out_Dest(Out_Dest), .Out_Flags(Out_Flags),
      .PSR(PSR), .Op_Count(Op_Count)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [W-1:0]  res;
      logic [DW-1:0] dest;
      logic [3:0]    flags;
   } ent_t;

   ent_t        q[$];
   logic [3:0]  m_psr;
   int unsigned m_cnt;
   int          vectors;
   int          miscompares;

   localparam logic [62:0] RESET_BUS = {1'b1, 62'b0};

   function automatic logic [62:0] exp_bus();
      ent_t h;
      h = '0;
      if (q.size() > 0) h = q[0];
      return {(q.size() < 2) ? 1'b1 : 1'b0, (q.size() > 0) ? 1'b1 : 1'b0,
              h.res, h.dest, h.flags, m_psr, m_cnt[15:0]};
   endfunction

   function automatic logic [62:0] got_bus();
      return {In_Ready, Out_Valid, Out_Result, Out_Dest, Out_Flags, PSR, Op_Count};
   endfunction

   task automatic model_reset();
      q.delete();
      m_psr = 4'b0000;
      m_cnt = 0;
   endtask

   task automatic drive(input logic iv, input logic [W-1:0] r, input logic c, input logic v,
                        input logic pw, input logic [DW-1:0] d, input logic ordy,
                        input logic fl);
      In_Valid = iv; ALU_Result = r; C = c; V = v; PSR_Write = pw; Dest = d;
      Out_Ready = ordy; Flush = fl;
   endtask

   // One clock edge: the model applies the same rules to the inputs seen at the edge.
   task automatic step();
      ent_t e;
      bit   rdy;
      @(posedge Clk);
      if (Reset_n) begin
         if (Flush) begin
            q.delete();
         end else begin
            rdy = (q.size() < 2);
            if (q.size() > 0 && Out_Ready) void'(q.pop_front());
            if (In_Valid && rdy) begin
               e.res   = ALU_Result;
               e.dest  = Dest;
               e.flags = {ALU_Result[W-1], (ALU_Result == 0), C, V};
               q.push_back(e);
               if (PSR_Write) m_psr = e.flags;
               if (m_cnt < 65535) m_cnt++;
            end
         end
      end
      #1;
   endtask

   task automatic pulse_reset();
      @(negedge Clk);
      Reset_n = 1'b0;
      model_reset();
      #2;
      Reset_n = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if (got_bus() !== RESET_BUS) begin
         miscompares++;
         $display("FAIL reset_state got %h want %h", got_bus(), RESET_BUS);
      end
      model_reset();
      @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   task automatic test_flags();
      drive(1, 32'h8000_0000, 1, 1, 1, 5'd3, 0, 0);
      step();
      vectors++;
      if ({Out_Valid, Out_Flags, PSR, Out_Dest} !== {1'b1, 4'b1011, 4'b1011, 5'd3}) begin
         miscompares++;
         $display("FAIL flags_first got v=%b f=%b psr=%b d=%0d want v=1 f=1011 psr=1011 d=3",
                  Out_Valid, Out_Flags, PSR, Out_Dest);
      end
      drive(1, 32'h0, 0, 0, 0, 5'd7, 0, 0);
      step();
      vectors++;
      if (PSR !== 4'b1011) begin
         miscompares++;
         $display("FAIL psr_hold got %b want 1011", PSR);
      end
      drive(0, 32'h0, 0, 0, 0, 5'd0, 1, 0);
      step();
      vectors++;
      if ({Out_Flags, Out_Dest} !== {4'b0100, 5'd7}) begin
         miscompares++;
         $display("FAIL flags_zero got f=%b d=%0d want f=0100 d=7", Out_Flags, Out_Dest);
      end
      vectors++;
      if (got_bus() !== exp_bus()) begin
         miscompares++;
         $display("FAIL flags_model got %h want %h", got_bus(), exp_bus());
      end
      step();
   endtask

   task automatic test_full_drain();
      logic [W-1:0] vals [3];
      vals[0] = 32'h1111_0001; vals[1] = 32'h2222_0002; vals[2] = 32'h3333_0003;
      pulse_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, vals[i], 0, 0, 0, 5'(i + 1), 0, 0);
         step();
      end
      vectors++;
      if ({In_Ready, Out_Valid, Op_Count, Out_Result} !== {1'b0, 1'b1, 16'd2, vals[0]}) begin
         miscompares++;
         $display("FAIL full_hold got rdy=%b v=%b cnt=%0d res=%h want rdy=0 v=1 cnt=2 res=%h",
                  In_Ready, Out_Valid, Op_Count, Out_Result, vals[0]);
      end
      drive(0, '0, 0, 0, 0, '0, 1, 0);
      step();
      vectors++;
      if ({Out_Valid, Out_Result, Out_Dest} !== {1'b1, vals[1], 5'd2}) begin
         miscompares++;
         $display("FAIL drain_order got v=%b res=%h d=%0d want v=1 res=%h d=2",
                  Out_Valid, Out_Result, Out_Dest, vals[1]);
      end
      step();
      vectors++;
      if ({Out_Valid, In_Ready, Out_Result} !== {1'b0, 1'b1, 32'h0}) begin
         miscompares++;
         $display("FAIL drain_empty got v=%b rdy=%b res=%h want v=0 rdy=1 res=0",
                  Out_Valid, In_Ready, Out_Result);
      end
   endtask

   task automatic test_push_pop_flush();
      logic [3:0]  psr_before;
      logic [15:0] cnt_before;
      drive(1, 32'hAAAA_0001, 0, 1, 1, 5'd9, 0, 0);
      step();
      drive(1, 32'hBBBB_0002, 1, 0, 0, 5'd10, 1, 0);
      step();
      vectors++;
      if ({Out_Valid, In_Ready, Out_Result, Out_Dest} !== {1'b1, 1'b1, 32'hBBBB_0002, 5'd10}) begin
         miscompares++;
         $display("FAIL push_pop got v=%b rdy=%b res=%h d=%0d want v=1 rdy=1 res=bbbb0002 d=10",
                  Out_Valid, In_Ready, Out_Result, Out_Dest);
      end
      psr_before = m_psr;
      cnt_before = m_cnt[15:0];
      drive(1, 32'hCCCC_0003, 1, 1, 1, 5'd11, 0, 1);
      step();
      vectors++;
      if ({Out_Valid, PSR, Op_Count} !== {1'b0, psr_before, cnt_before}) begin
         miscompares++;
         $display("FAIL flush got v=%b psr=%b cnt=%0d want v=0 psr=%b cnt=%0d",
                  Out_Valid, PSR, Op_Count, psr_before, cnt_before);
      end
      drive(0, '0, 0, 0, 0, '0, 0, 0);
   endtask

   task automatic test_random();
      logic [W-1:0] r;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(3))
            0:       r = '0;
            1:       r = 32'h8000_0000 | $urandom;
            default: r = $urandom;
         endcase
         drive($urandom_range(3) != 0, r, 1'($urandom), 1'($urandom), 1'($urandom),
               DW'($urandom), $urandom_range(2) != 0, $urandom_range(15) == 0);
         step();
         vectors++;
         if (got_bus() !== exp_bus()) begin
            miscompares++;
            $display("FAIL random[%0d] got %h want %h", i, got_bus(), exp_bus());
         end
      end
      drive(0, '0, 0, 0, 0, '0, 0, 0);
   endtask

   task automatic test_async_reset();
      drive(0, '0, 0, 0, 0, '0, 0, 1);
      step();
      drive(1, 32'h1234_5678, 1, 0, 1, 5'd4, 0, 0);
      step();
      drive(1, 32'h9ABC_DEF0, 0, 1, 1, 5'd5, 0, 0);
      step();
      vectors++;
      if (got_bus() !== exp_bus()) begin
         miscompares++;
         $display("FAIL prefill got %h want %h", got_bus(), exp_bus());
      end
      @(negedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      vectors++;
      if (got_bus() !== RESET_BUS) begin
         miscompares++;
         $display("FAIL async_reset got %h want %h", got_bus(), RESET_BUS);
      end
      model_reset();
      step();
      vectors++;
      if (got_bus() !== RESET_BUS) begin
         miscompares++;
         $display("FAIL reset_held got %h want %h", got_bus(), RESET_BUS);
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      drive(1, 32'h0000_0042, 0, 0, 1, 5'd6, 0, 0);
      step();
      vectors++;
      if ({Out_Valid, Out_Result, Op_Count} !== {1'b1, 32'h42, 16'd1}) begin
         miscompares++;
         $display("FAIL post_reset got v=%b res=%h cnt=%0d want v=1 res=00000042 cnt=1",
                  Out_Valid, Out_Result, Op_Count);
      end
      vectors++;
      if (got_bus() !== exp_bus()) begin
         miscompares++;
         $display("FAIL post_reset_model got %h want %h", got_bus(), exp_bus());
      end
   endtask

   task automatic test_saturation();
      pulse_reset();
      drive(1, 32'h5, 0, 0, 0, 5'd1, 1, 0);
      for (int i = 0; i < 65535; i++) step();
      vectors++;
      if (Op_Count !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL sat_reach got %h want ffff", Op_Count);
      end
      step();
      vectors++;
      if (Op_Count !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL sat_hold got %h want ffff", Op_Count);
      end
      vectors++;
      if (got_bus() !== exp_bus()) begin
         miscompares++;
         $display("FAIL sat_model got %h want %h", got_bus(), exp_bus());
      end
      drive(0, '0, 0, 0, 0, '0, 0, 0);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      model_reset();
      test_reset();
      test_flags();
      test_full_drain();
      test_push_pop_flush();
      test_random();
      test_async_reset();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
